// File: rtl/keystream_xor_packer_pkg.sv
// Shared types and constants for the keystream packing path.
// Imported by the packer, its shift sub-block and the bus interface.
package stream_cipher_pkg;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } fill_state_e;

   localparam int DEF_WIDTH = 8;
   localparam int WCNT_W    = 8;

endpackage

// File: rtl/keystream_xor_packer_if.sv
// Keystream, plaintext and ciphertext handshakes of the packer.
// master = stimulus/integration side, slave = the packer.
interface keystream_xor_packer_if
   import stream_cipher_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) ();

   logic              ks_bit;
   logic              ks_valid;
   logic              ks_ready;
   logic [WIDTH-1:0]  pt_data;
   logic              pt_valid;
   logic              pt_ready;
   logic [WIDTH-1:0]  ct_data;
   logic              ct_valid;
   logic              ct_ready;
   logic [WCNT_W-1:0] word_cnt;

   modport master (
      output ks_bit, ks_valid,
      output pt_data, pt_valid,
      output ct_ready,
      input  ks_ready, pt_ready,
      input  ct_data, ct_valid,
      input  word_cnt
   );

   modport slave (
      input  ks_bit, ks_valid,
      input  pt_data, pt_valid,
      input  ct_ready,
      output ks_ready, pt_ready,
      output ct_data, ct_valid,
      output word_cnt
   );

endinterface

// File: rtl/keystream_xor_packer_shift.sv
// Serial-to-parallel key shifter with FILL/HOLD sequencing.
// Raises xfer_o for one cycle when a full word moves to the key buffer.
module ks_shift_packer
   import stream_cipher_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk_i,
   input  logic             nrst_i,
   input  logic             ks_bit_i,
   input  logic             ks_valid_i,
   input  logic             xfer_ok_i,
   output logic             ks_ready_o,
   output logic             xfer_o,
   output logic [WIDTH-1:0] sreg_o
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   fill_state_e      state_q;
   logic [CW-1:0]    bit_cnt_q;
   logic [WIDTH-1:0] sreg_q;
   logic [WIDTH-1:0] sreg_d;

   assign ks_ready_o = (state_q == FILL);
   assign xfer_o     = (state_q == HOLD) && xfer_ok_i;
   assign sreg_o     = sreg_q;

   // First accepted bit ends up at the MSB or the LSB of the word
   always_comb begin
      sreg_d = sreg_q;
      if (MSB_FIRST) begin
         sreg_d = {sreg_q[WIDTH-2:0], ks_bit_i};
      end else begin
         sreg_d = {ks_bit_i, sreg_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         state_q   <= FILL;
         bit_cnt_q <= '0;
         sreg_q    <= '0;
      end else begin
         unique case (state_q)
            FILL: begin
               if (ks_valid_i) begin
                  sreg_q    <= sreg_d;
                  bit_cnt_q <= bit_cnt_q + CW'(1);
                  if (bit_cnt_q == LAST) begin
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (xfer_ok_i) begin
                  bit_cnt_q <= '0;
                  state_q   <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

endmodule

// File: rtl/keystream_xor_packer.sv
// Packs keystream bits into key words and XORs them with plaintext.
// Double-buffered key, single registered ciphertext stage.
module keystream_xor_packer
   import stream_cipher_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input logic                   clk,
   input logic                   nrst,
   keystream_xor_packer_if.slave bus
);

   logic [WIDTH-1:0]  sreg;
   logic              xfer;
   logic              xfer_ok;
   logic              pt_hs;
   logic              ct_hs;

   logic [WIDTH-1:0]  key_buf_q,  key_buf_d;
   logic              key_full_q, key_full_d;
   logic [WIDTH-1:0]  ct_data_q,  ct_data_d;
   logic              ct_valid_q, ct_valid_d;
   logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;

   assign bus.pt_ready = key_full_q && (!ct_valid_q || bus.ct_ready);
   assign bus.ct_data  = ct_data_q;
   assign bus.ct_valid = ct_valid_q;
   assign bus.word_cnt = word_cnt_q;

   assign pt_hs   = bus.pt_valid && bus.pt_ready;
   assign ct_hs   = ct_valid_q && bus.ct_ready;
   // Key buffer frees up in the same cycle it is consumed
   assign xfer_ok = !key_full_q || pt_hs;

   ks_shift_packer #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shift (
      .clk_i      (clk),
      .nrst_i     (nrst),
      .ks_bit_i   (bus.ks_bit),
      .ks_valid_i (bus.ks_valid),
      .xfer_ok_i  (xfer_ok),
      .ks_ready_o (bus.ks_ready),
      .xfer_o     (xfer),
      .sreg_o     (sreg)
   );

   always_comb begin
      key_buf_d  = key_buf_q;
      key_full_d = key_full_q;
      ct_data_d  = ct_data_q;
      ct_valid_d = ct_valid_q;
      word_cnt_d = word_cnt_q;
      if (pt_hs) begin
         key_full_d = 1'b0;
      end
      if (xfer) begin
         key_buf_d  = sreg;
         key_full_d = 1'b1;
      end
      if (pt_hs) begin
         ct_data_d  = bus.pt_data ^ key_buf_q;
         ct_valid_d = 1'b1;
      end else if (ct_hs) begin
         ct_valid_d = 1'b0;
      end
      if (ct_hs) begin
         word_cnt_d = word_cnt_q + WCNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         key_buf_q  <= '0;
         key_full_q <= 1'b0;
         ct_data_q  <= '0;
         ct_valid_q <= 1'b0;
         word_cnt_q <= '0;
      end else begin
         key_buf_q  <= key_buf_d;
         key_full_q <= key_full_d;
         ct_data_q  <= ct_data_d;
         ct_valid_q <= ct_valid_d;
         word_cnt_q <= word_cnt_d;
      end
   end

endmodule

// File: tb/tb_keystream_xor_packer.sv
// Directed and randomised bench for keystream_xor_packer.
// Word-level model: key k = accepted bits k*W..k*W+W-1, ct j = pt j ^ key j.
module tb_keystream_xor_packer;
   import stream_cipher_pkg::*;

   localparam int W = 8;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   keystream_xor_packer_if #(.WIDTH(W)) b0 ();
   keystream_xor_packer_if #(.WIDTH(W)) b1 ();

   keystream_xor_packer #(.WIDTH(W), .MSB_FIRST(1'b1)) u0 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (b0)
   );

   keystream_xor_packer #(.WIDTH(W), .MSB_FIRST(1'b0)) u1 (
      .clk  (clk),
      .nrst (nrst),
      .bus  (b1)
   );

   int checks = 0;
   int errors = 0;

   bit         ks_q[$];
   logic [W-1:0] pt_q[$];
   bit         acc[$];
   logic [W-1:0] key_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] ct_log[$];
   logic [7:0] mdl_wc = 8'd0;
   int         n_ct = 0;
   bit         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   bit         rnd = 1'b0;
   bit         ct_rdy = 1'b1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic push_word(input logic [W-1:0] v);
      for (int i = W - 1; i >= 0; i--) ks_q.push_back(v[i]);
   endtask

   task automatic drive();
      b0.ks_valid = (ks_q.size() > 0);
      b0.ks_bit   = (ks_q.size() > 0) ? ks_q[0] : 1'b0;
      b0.pt_valid = (pt_q.size() > 0) &&
                    (!rnd || ($urandom_range(0, 3) != 0));
      b0.pt_data  = (pt_q.size() > 0) ? pt_q[0] : '0;
      b0.ct_ready = rnd ? ($urandom_range(0, 3) != 0) : ct_rdy;
   endtask

   task automatic flush_model();
      acc.delete();
      key_q.delete();
      exp_q.delete();
      mdl_wc     = 8'd0;
      prev_stall = 1'b0;
   endtask

   // One clock: check at negedge, then advance sources after posedge
   task automatic cycle();
      bit ks_hs, pt_hs, ct_hs;
      logic [W-1:0] k;
      @(negedge clk);
      ks_hs = b0.ks_valid && b0.ks_ready;
      pt_hs = b0.pt_valid && b0.pt_ready;
      ct_hs = b0.ct_valid && b0.ct_ready;
      chk("word_cnt", b0.word_cnt, mdl_wc);
      chk("ct_valid", b0.ct_valid, exp_q.size() != 0);
      if (prev_stall)
         chk("ct_hold", {b0.ct_valid, b0.ct_data}, {1'b1, prev_data});
      chk("pt_gate", b0.pt_ready && b0.ct_valid && !b0.ct_ready, 0);
      chk("key_depth", key_q.size() <= 2, 1);
      if (key_q.size() >= 2) chk("ks_stall", b0.ks_ready, 0);
      if (ct_hs) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ct_spurious: got %0h expected none", b0.ct_data);
         end else begin
            chk("ct_data", b0.ct_data, exp_q.pop_front());
         end
         ct_log.push_back(b0.ct_data);
         mdl_wc++;
         n_ct++;
      end
      if (pt_hs) begin
         if (key_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pt_early: got pt_ready=1 expected 0");
         end else begin
            exp_q.push_back(b0.pt_data ^ key_q.pop_front());
         end
      end
      if (ks_hs) begin
         acc.push_back(b0.ks_bit);
         if (acc.size() == W) begin
            k = '0;
            for (int i = 0; i < W; i++) k[W-1-i] = acc[i];
            key_q.push_back(k);
            acc.delete();
         end
      end
      prev_stall = b0.ct_valid && !b0.ct_ready;
      prev_data  = b0.ct_data;
      @(posedge clk);
      #1;
      if (ks_hs) void'(ks_q.pop_front());
      if (pt_hs) void'(pt_q.pop_front());
      drive();
   endtask

   task automatic run_until(input int target, input int budget,
                            input string name);
      int c;
      c = 0;
      while (n_ct < target && c < budget) begin
         cycle();
         c++;
      end
      chk({name, "_done"}, n_ct >= target, 1);
   endtask

   task automatic do_reset();
      ks_q.delete();
      pt_q.delete();
      nrst = 1'b0;
      drive();
      @(posedge clk);
      @(negedge clk);
      chk("rst_ct_valid", b0.ct_valid, 0);
      chk("rst_ct_data", b0.ct_data, 0);
      chk("rst_word_cnt", b0.word_cnt, 0);
      chk("rst_pt_ready", b0.pt_ready, 0);
      chk("rst_ks_ready", b0.ks_ready, 1);
      flush_model();
      @(posedge clk);
      #1;
      nrst = 1'b1;
      drive();
   endtask

   initial begin
      int n0;
      int c;
      bit ok;
      logic [W-1:0] lsb_bits;

      b1.ks_bit   = 1'b0;
      b1.ks_valid = 1'b0;
      b1.pt_data  = '0;
      b1.pt_valid = 1'b0;
      b1.ct_ready = 1'b1;
      do_reset();

      // LSB-first instance: bits 1,0,0,0,0,0,0,0 with pt 0x00 -> 0x01
      lsb_bits = 8'h01;
      b1.ks_valid = 1'b1;
      for (int i = 0; i < W; i++) begin
         b1.ks_bit = lsb_bits[i];
         c = 0;
         do begin
            @(negedge clk);
            ok = b1.ks_ready;
            @(posedge clk);
            #1;
            c++;
         end while (!ok && c < 20);
      end
      b1.ks_valid = 1'b0;
      b1.pt_valid = 1'b1;
      c = 0;
      do begin
         @(negedge clk);
         ok = b1.ct_valid;
         c++;
      end while (!ok && c < 20);
      chk("lsb_ct_valid", b1.ct_valid, 1);
      chk("lsb_ct_data", b1.ct_data, 8'h01);
      @(posedge clk);
      #1;
      b1.pt_valid = 1'b0;

      // Single word: keystream 0xA5, pt 0xFF -> 0x5A
      do_reset();
      push_word(8'hA5);
      pt_q.push_back(8'hFF);
      ct_rdy = 1'b1;
      drive();
      n0 = n_ct;
      c = 0;
      while (!b0.pt_ready && c < 30) begin
         cycle();
         c++;
      end
      chk("t1_pt_ready", b0.pt_ready, 1);
      chk("t1_bits_used", W - ks_q.size(), W);
      run_until(n0 + 1, 20, "t1");
      chk("t1_ct", ct_log[ct_log.size()-1], 8'h5A);
      chk("t1_word_cnt", b0.word_cnt, 1);

      // All-ones keystream against three back-to-back plaintexts
      do_reset();
      for (int i = 0; i < 3; i++) push_word(8'hFF);
      pt_q.push_back(8'h00);
      pt_q.push_back(8'h5A);
      pt_q.push_back(8'hFF);
      drive();
      n0 = n_ct;
      run_until(n0 + 3, 80, "t2");
      chk("t2_ct0", ct_log[ct_log.size()-3], 8'hFF);
      chk("t2_ct1", ct_log[ct_log.size()-2], 8'hA5);
      chk("t2_ct2", ct_log[ct_log.size()-1], 8'h00);

      // Sink stall with ciphertext pending
      do_reset();
      push_word(8'hC3);
      push_word(8'h81);
      push_word(8'h7E);
      pt_q.push_back(8'h00);
      pt_q.push_back(8'h00);
      ct_rdy = 1'b0;
      drive();
      n0 = n_ct;
      c = 0;
      while (!b0.ct_valid && c < 40) begin
         cycle();
         c++;
      end
      chk("t3_pending", b0.ct_valid, 1);
      c = 0;
      while (key_q.size() < 2 && c < 60) begin
         cycle();
         c++;
      end
      for (int i = 0; i < 5; i++) cycle();
      chk("t3_ks_ready", b0.ks_ready, 0);
      chk("t3_pt_ready", b0.pt_ready, 0);
      chk("t3_ct_held", b0.ct_data, 8'hC3);
      push_word(8'h55);
      pt_q.push_back(8'h00);
      pt_q.push_back(8'h00);
      ct_rdy = 1'b1;
      drive();
      run_until(n0 + 4, 100, "t3");
      chk("t3_ct0", ct_log[ct_log.size()-4], 8'hC3);
      chk("t3_ct1", ct_log[ct_log.size()-3], 8'h81);
      chk("t3_ct2", ct_log[ct_log.size()-2], 8'h7E);
      chk("t3_ct3", ct_log[ct_log.size()-1], 8'h55);

      // Reset with a partial key and a pending ciphertext
      do_reset();
      push_word(8'hFF);
      ks_q.push_back(1'b1);
      ks_q.push_back(1'b1);
      ks_q.push_back(1'b1);
      pt_q.push_back(8'h00);
      ct_rdy = 1'b0;
      drive();
      c = 0;
      while ((!b0.ct_valid || ks_q.size() != 0) && c < 40) begin
         cycle();
         c++;
      end
      chk("t4_pre_valid", b0.ct_valid, 1);
      do_reset();
      push_word(8'h3C);
      pt_q.push_back(8'h00);
      ct_rdy = 1'b1;
      drive();
      n0 = n_ct;
      run_until(n0 + 1, 30, "t4");
      chk("t4_ct", ct_log[ct_log.size()-1], 8'h3C);
      chk("t4_word_cnt", b0.word_cnt, 1);

      // 256 hand-offs wrap the word counter
      do_reset();
      for (int i = 0; i < 256; i++) begin
         push_word(W'($urandom_range(0, 255)));
         pt_q.push_back(W'($urandom_range(0, 255)));
      end
      drive();
      n0 = n_ct;
      run_until(n0 + 256, 256 * 12, "wrap");
      chk("wrap_word_cnt", b0.word_cnt, 0);

      // Random pt_valid / ct_ready against the model
      do_reset();
      rnd = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         push_word(W'($urandom_range(0, 255)));
         pt_q.push_back(W'($urandom_range(0, 255)));
      end
      drive();
      n0 = n_ct;
      run_until(n0 + 1000, 1000 * 40, "rand");
      rnd = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
